// File: rtl/sequence_serializer.sv
`default_nettype none
// sequence_serializer: parallel-to-serial front end for the sequence detector.
// One-word holding buffer allows gapless streaming; outputs are registered.
// Revision: 1.0
module sequence_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_BIT   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  sequence_out,
  output logic                  bit_valid,
  output logic                  word_done,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [DATA_WIDTH-1:0] hold_reg, hold_next;
  logic [DATA_WIDTH-1:0] shifted;
  logic [CW-1:0]         bit_cnt, cnt_next;
  logic                  shift_active, active_next;
  logic                  hold_full, hold_full_next;
  logic                  accept;
  logic                  at_last;
  logic                  shifter_free;
  logic                  out_bit;
  logic                  seq_q, bit_valid_q, word_done_q;

  assign data_ready   = reset & ~hold_full;
  assign accept       = data_valid & data_ready;
  assign at_last      = shift_active & (bit_cnt == LAST_BIT);
  assign shifter_free = ~shift_active | at_last;
  assign busy         = shift_active | hold_full;

  // The output end of the shifter is the MSB or LSB depending on bit order.
  assign out_bit = MSB_FIRST ? shift_reg[DATA_WIDTH-1] : shift_reg[0];
  assign shifted = MSB_FIRST ? {shift_reg[DATA_WIDTH-2:0], 1'b0}
                             : {1'b0, shift_reg[DATA_WIDTH-1:1]};

  always_comb begin
    shift_next     = shift_reg;
    cnt_next       = bit_cnt;
    active_next    = shift_active;
    hold_next      = hold_reg;
    hold_full_next = hold_full;

    if (shifter_free) begin
      // Held word has priority; data_ready is low whenever it is present.
      if (hold_full) begin
        shift_next     = hold_reg;
        cnt_next       = '0;
        active_next    = 1'b1;
        hold_full_next = 1'b0;
      end else if (accept) begin
        shift_next  = data_in;
        cnt_next    = '0;
        active_next = 1'b1;
      end else begin
        cnt_next    = '0;
        active_next = 1'b0;
      end
    end else begin
      shift_next = shifted;
      cnt_next   = bit_cnt + 1'b1;
      if (accept) begin
        hold_next      = data_in;
        hold_full_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg    <= '0;
      hold_reg     <= '0;
      bit_cnt      <= '0;
      shift_active <= 1'b0;
      hold_full    <= 1'b0;
    end else begin
      shift_reg    <= shift_next;
      hold_reg     <= hold_next;
      bit_cnt      <= cnt_next;
      shift_active <= active_next;
      hold_full    <= hold_full_next;
    end
  end

  // Output stage shows the bit selected by the shifter state before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_q       <= IDLE_BIT;
      bit_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      seq_q       <= shift_active ? out_bit : IDLE_BIT;
      bit_valid_q <= shift_active;
      word_done_q <= at_last;
    end
  end

  assign sequence_out = seq_q;
  assign bit_valid    = bit_valid_q;
  assign word_done    = word_done_q;

endmodule
`default_nettype wire

// File: doc/sequence_serializer.md
# sequence_serializer

Parallel-to-serial front end for the sequence detector. It accepts DATA_WIDTH-bit words over a valid/ready handshake and drives one bit per clock onto the detector's serial input. A one-word holding buffer lets consecutive words stream with no idle bit between them. It also provides a bit-valid strobe and an end-of-word pulse for alignment checks.

## Interface
- DATA_WIDTH, 8: word width in bits; must be at least 2.
- MSB_FIRST, 1: 1 means bit DATA_WIDTH-1 is sent first; 0 means bit 0 is sent first.
- IDLE_BIT, 0: level driven on sequence_out when no word is being shifted.
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset; asserting it low clears all state immediately, independent of clk.
- data_in, input, DATA_WIDTH: parallel word.
- data_valid, input, 1: data_in is valid.
- data_ready, output, 1: block can accept a word. Transfer occurs on a rising edge with data_valid and data_ready both high.
- sequence_out, output, 1: serial bit to the detector (registered).
- bit_valid, output, 1: sequence_out carries a word bit this cycle (registered).
- word_done, output, 1: high during the last bit of each word (registered).
- busy, output, 1: shifter or holding buffer occupied.

## Operation
- Storage:
  - shift register and bit counter of width $clog2(DATA_WIDTH), plus a shift_active flag;
  - one holding register with a hold_full flag.
- data_ready is !hold_full and is forced to 0 while reset is low.
- busy is shift_active or hold_full.
- The shifter is free on a given edge if shift_active is 0, or if the counter is at DATA_WIDTH-1 (last bit being shown this cycle).
- Accepted word, hold empty, shifter free: the word loads straight into the shifter and the counter clears to 0.
- Accepted word otherwise: the word goes into the holding register and hold_full becomes 1.
- Shifter free and hold_full: the holding word moves to the shifter, hold_full clears, and the counter resets. Accept is impossible that cycle because data_ready is 0.
- Shifting:
  - each edge while active, the counter increments and the register shifts toward the output end;
  - at the last bit with no next word available, shift_active clears.
- Output register, updated every edge:
  - sequence_out is the current output-end bit when active, else IDLE_BIT;
  - bit_valid equals shift_active;
  - word_done is 1 when the counter equals DATA_WIDTH-1.
- Bit order: with MSB_FIRST=1, output bit k of a word is data_in[DATA_WIDTH-1-k]; with MSB_FIRST=0 it is data_in[k].
- data_in is sampled only on the accept edge; later changes have no effect.
- Reset low (asynchronous), at any point including mid-word:
  - shift_active, hold_full and the counter clear to 0;
  - the word in progress and the held word are discarded;
  - outputs go to reset values.
- Reset values: sequence_out=IDLE_BIT, bit_valid=0, word_done=0, busy=0. data_ready=0 while reset is low and 1 from the first cycle after release.

## Timing
- Latency: a word accepted on edge N presents its first bit, with bit_valid=1, in the cycle after edge N+1. That is two edges, because of the output register.
- Each word occupies exactly DATA_WIDTH consecutive bit_valid cycles.
- Throughput: a word accepted while another is shifting starts immediately after its last bit, giving gapless streaming at 1 bit per clock.
- data_ready:
  - drops the edge after a word enters the holding register;
  - rises again the edge after that word moves to the shifter.
- The detector samples sequence_out every clock. Idle gaps therefore inject IDLE_BIT bits into its state; upstream keeps the holding buffer fed when a continuous stream is required.

## Test plan
- Single word, MSB_FIRST=1, data_in=8'hB4 accepted at edge 1: bits 1,0,1,1,0,1,0,0 appear in cycles 3–10 with bit_valid=1, word_done=1 only in cycle 10, then sequence_out=0, bit_valid=0, busy=0.
- Back-to-back 8'hB5 then 8'h0F with data_valid held high: 16 consecutive bit_valid cycles with no gap. data_ready is 0 while the second word is held. word_done pulses in the 8th and 16th bit cycles.
- End-to-end with the detector: 8'hB5 (10110101) MSB first → detector asserts detected during the 8th serial bit.
- MSB_FIRST=0, DATA_WIDTH=8, word 8'h01 → first bit 1, then seven 0s.
- Reset low mid-word (after bit 3 of 8'hFF, hold loaded with 8'hAA): outputs go to reset values at once, without waiting for a clock. After release, no bits of either word ever appear and data_ready=1.
- Idle gap with IDLE_BIT=1: between words, sequence_out=1 and bit_valid=0.
